// File: rtl/md_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the mul/div sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package md_ctrl_pkg;

  // Instruction field values that select the multi-cycle unit
  localparam logic [4:0] R_OP    = 5'b00000;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Exception reporting goes through rstatus with an op-specific code
  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MUL     = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  // rstatus code for a failed operation of the given kind
  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? EXC_DIV : EXC_MUL;
  endfunction

endpackage

// File: rtl/md_insn_decode.sv
// Recognises mul/div in DX and extracts the destination register.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode, also used by the hazard unit.
module md_insn_decode
  import md_ctrl_pkg::*;
(
  input  logic [31:0] i_insn,
  input  logic        i_valid,
  output logic        o_is_md,
  output logic        o_is_div,
  output logic [4:0]  o_rd
);

  logic [4:0] w_opcode;
  logic [4:0] w_alu_op;
  logic       w_is_rop;
  logic       w_unused;

  assign w_opcode = i_insn[31:27];
  assign w_alu_op = i_insn[6:2];
  assign w_is_rop = (w_opcode == R_OP);

  // Bubbles never count as mul/div, whatever bits they carry
  assign o_is_md  = i_valid & w_is_rop & ((w_alu_op == ALU_MUL) | (w_alu_op == ALU_DIV));
  assign o_is_div = (w_alu_op == ALU_DIV);
  assign o_rd     = i_insn[26:22];

  // Remaining instruction fields play no part in this decode
  assign w_unused = ^{i_insn[21:7], i_insn[1:0]};

endmodule

// File: rtl/multdiv_controller.sv
// Sequences the shared multiplier/divider for one DX mul/div at a time.
// Latency: start pulse 1 cycle after decode; writeback 1 cycle after unit ready or timeout.
// Backpressure: holds stall from decode until the unit answers, times out or is flushed.
module multdiv_controller
  import md_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_dx_insn,
  input  logic        i_dx_valid,
  input  logic [31:0] i_dx_op_a,
  input  logic [31:0] i_dx_op_b,
  input  logic        i_flush,
  output logic        o_md_ctrl_mult,
  output logic        o_md_ctrl_div,
  output logic [31:0] o_md_op_a,
  output logic [31:0] o_md_op_b,
  input  logic [31:0] i_md_result,
  input  logic        i_md_ready,
  input  logic        i_md_exception,
  output logic        o_stall,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data
);

  // Last BUSY count before the operation is declared dead
  localparam logic [CNT_W-1:0] LP_LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic             w_is_md;
  logic             w_is_div;
  logic [4:0]       w_rd;
  logic             w_issue;

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [4:0]       r_rd;
  logic             r_is_div;
  logic             r_mult;
  logic             r_div;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_data;

  md_insn_decode u_decode (
    .i_insn   (i_dx_insn),
    .i_valid  (i_dx_valid),
    .o_is_md  (w_is_md),
    .o_is_div (w_is_div),
    .o_rd     (w_rd)
  );

  // Decode is only honoured in IDLE, so the instruction sitting in DX during DONE cannot retrigger
  assign w_issue = (r_state == ST_IDLE) & w_is_md & ~i_flush;

  // Freeze the front of the pipe from decode until the result is handed back
  assign o_stall = w_issue | (r_state == ST_START) | (r_state == ST_BUSY);

  // Sequencer: latch operands, pulse the unit, wait for ready or timeout, write back once
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_rd       <= '0;
      r_is_div   <= 1'b0;
      r_mult     <= 1'b0;
      r_div      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      // Pulses and writeback last a single cycle unless re-armed below
      r_mult     <= 1'b0;
      r_div      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_op_a   <= i_dx_op_a;
            r_op_b   <= i_dx_op_b;
            r_rd     <= w_rd;
            r_is_div <= w_is_div;
            r_mult   <= ~w_is_div;
            r_div    <= w_is_div;
            r_state  <= ST_START;
          end
        end
        ST_START: begin
          // The unit cannot answer in its start cycle, so md_ready is not looked at here
          r_cnt   <= '0;
          r_state <= i_flush ? ST_IDLE : ST_BUSY;
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (i_flush) begin
            r_state <= ST_IDLE;
          end else if (i_md_ready) begin
            r_state <= ST_DONE;
            if (i_md_exception) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= RSTATUS_REG;
              r_wb_data  <= exc_code(r_is_div);
            end else if (r_rd != 5'd0) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= i_md_result;
            end
          end else if (r_cnt == LP_LAST_CNT) begin
            // Unit never answered: report it like a unit exception
            r_state    <= ST_DONE;
            r_wb_valid <= 1'b1;
            r_wb_rd    <= RSTATUS_REG;
            r_wb_data  <= exc_code(r_is_div);
          end
        end
        ST_DONE: begin
          // Writeback is already committed; a flush here does not cancel it
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_md_ctrl_mult = r_mult;
  assign o_md_ctrl_div  = r_div;
  assign o_md_op_a      = r_op_a;
  assign o_md_op_b      = r_op_b;
  assign o_wb_valid     = r_wb_valid;
  assign o_wb_rd        = r_wb_rd;
  assign o_wb_data      = r_wb_data;

endmodule

// File: tb/tb_multdiv_controller.sv
// Randomised scoreboard bench for multdiv_controller; the bench also plays the mul/div unit.
// Latency: expected writebacks are queued at issue and popped by an independent monitor.
// Backpressure: every wait is bounded by a cycle budget.
module tb_multdiv_controller;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dx_insn;
  logic        dx_valid;
  logic [31:0] dx_op_a;
  logic [31:0] dx_op_b;
  logic        flush;
  logic        mult;
  logic        div;
  logic [31:0] md_op_a;
  logic [31:0] md_op_b;
  logic [31:0] md_result;
  logic        md_ready;
  logic        md_exception;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  multdiv_controller #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_dx_insn      (dx_insn),
    .i_dx_valid     (dx_valid),
    .i_dx_op_a      (dx_op_a),
    .i_dx_op_b      (dx_op_b),
    .i_flush        (flush),
    .o_md_ctrl_mult (mult),
    .o_md_ctrl_div  (div),
    .o_md_op_a      (md_op_a),
    .o_md_op_b      (md_op_b),
    .i_md_result    (md_result),
    .i_md_ready     (md_ready),
    .i_md_exception (md_exception),
    .o_stall        (stall),
    .o_wb_valid     (wb_valid),
    .o_wb_rd        (wb_rd),
    .o_wb_data      (wb_data)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_total  = 0;
  int   n_pass   = 0;
  int   mult_cnt = 0;
  int   div_cnt  = 0;
  bit   started  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pulse bookkeeping and writeback scoreboard, independent of the stimulus
  always @(negedge clk) begin
    if (started) begin
      if (mult === 1'b1) mult_cnt++;
      if (div === 1'b1) div_cnt++;
      chk("pulse_onehot", 32'(mult & div), 32'd0);
      if (wb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'(wb_rd), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          chk("wb_data", wb_data, e.data);
        end
      end else begin
        chk("wb_rd_idle", 32'(wb_rd), 32'd0);
        chk("wb_data_idle", wb_data, 32'd0);
      end
    end
  end

  function automatic logic [31:0] mk_insn(input bit dv, input logic [4:0] rd);
    logic [31:0] w;
    w        = $urandom;
    w[31:27] = 5'd0;
    w[26:22] = rd;
    w[6:2]   = dv ? 5'd7 : 5'd6;
    return w;
  endfunction

  // Non-mul/div traffic: never stalls, never pulses; stray md_ready must be ignored
  task automatic noise(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      int k;
      int v;
      k = $urandom_range(0, 2);
      w = $urandom;
      case (k)
        0: begin
          w = mk_insn(1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)));
          dx_valid = 1'b0;
        end
        1: begin
          w[31:27] = 5'($urandom_range(1, 31));
          w[6:2]   = 5'd6;
          dx_valid = 1'b1;
        end
        default: begin
          v = $urandom_range(0, 29);
          if (v >= 6) v += 2;
          w[31:27] = 5'd0;
          w[6:2]   = 5'(v);
          dx_valid = 1'b1;
        end
      endcase
      dx_insn      = w;
      md_ready     = 1'($urandom_range(0, 1));
      md_exception = 1'($urandom_range(0, 1));
      md_result    = $urandom;
      @(negedge clk);
      chk("noise_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
    end
    dx_valid = 1'b0;
    md_ready = 1'b0;
  endtask

  // One mul/div in DX. lat: cycles from start pulse to md_ready (-1 = never).
  // abort_at: cycle (0 = decode cycle) in which flush or reset is raised, -1 = none.
  task automatic issue(input bit dv, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input bit exc,
                       input int abort_at, input bit abort_rst);
    exp_t        e;
    int          nst;
    int          exp_st;
    int          mp0;
    int          dp0;
    bit          aborted;
    bit          np;
    bit          done;
    logic [31:0] res;
    nst     = 0;
    mp0     = mult_cnt;
    dp0     = div_cnt;
    aborted = (abort_at >= 0);
    np      = !(aborted && abort_at == 0);
    done    = 1'b0;
    res     = dv ? ((b == 0) ? 32'd0 : a / b) : a * b;

    // Reference: what the register file should see for this instruction
    if (!aborted) begin
      if (exc || lat < 0) begin
        e.rd = 5'd30; e.data = dv ? 32'd5 : 32'd4; exp_q.push_back(e);
      end else if (rd != 5'd0) begin
        e.rd = rd; e.data = res; exp_q.push_back(e);
      end
    end
    if (aborted) exp_st = (abort_rst || abort_at > 0) ? abort_at + 1 : 0;
    else if (lat < 0) exp_st = TO + 2;
    else exp_st = lat + 2;

    dx_insn  = mk_insn(dv, rd);
    dx_valid = 1'b1;
    dx_op_a  = a;
    dx_op_b  = b;
    for (int c = 0; c < TO + 20 && !done; c++) begin
      md_ready     = (lat >= 0 && c == lat + 1);
      md_result    = md_ready ? res : $urandom;
      md_exception = md_ready ? exc : 1'($urandom_range(0, 1));
      flush        = aborted && !abort_rst && c == abort_at;
      reset        = aborted && abort_rst && c == abort_at;
      @(negedge clk);
      if (c == 1 && np) begin
        chk("pulse_mult", 32'(mult), 32'(!dv));
        chk("pulse_div", 32'(div), 32'(dv));
        chk("op_a", md_op_a, a);
        chk("op_b", md_op_b, b);
      end
      if (stall) nst++;
      else done = 1'b1;
      if (done && aborted && abort_rst) begin
        chk("rst_mult", 32'(mult), 32'd0);
        chk("rst_div", 32'(div), 32'd0);
        chk("rst_op_a", md_op_a, 32'd0);
        chk("rst_op_b", md_op_b, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      end
      @(posedge clk); #1;
      if (done || (aborted && c == abort_at)) dx_valid = 1'b0;
    end
    chk("stall_cycles", 32'(nst), 32'(exp_st));
    dx_valid = 1'b0;
    md_ready = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    chk("no_retrigger", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("mult_pulses", 32'(mult_cnt - mp0), 32'(np && !dv));
    chk("div_pulses", 32'(div_cnt - dp0), 32'(np && dv));
    chk("wb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    dx_insn      = '0;
    dx_valid     = 1'b0;
    dx_op_a      = '0;
    dx_op_b      = '0;
    flush        = 1'b0;
    md_result    = '0;
    md_ready     = 1'b0;
    md_exception = 1'b0;
    @(posedge clk); #1;
    started = 1'b1;
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_mult", 32'(mult), 32'd0);
    chk("reset_div", 32'(div), 32'd0);
    chk("reset_op_a", md_op_a, 32'd0);
    chk("reset_op_b", md_op_b, 32'd0);
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(1'b0, 5'd3, 32'd7, 32'd6, 16, 1'b0, -1, 1'b0);   // 7*6 -> r3
    issue(1'b1, 5'd5, 32'd100, 32'd0, 4, 1'b1, -1, 1'b0);  // divide by zero
    issue(1'b0, 5'd0, 32'd9, 32'd9, 3, 1'b0, -1, 1'b0);    // r0 never written
    issue(1'b0, 5'd7, 32'd2, 32'd3, -1, 1'b0, -1, 1'b0);   // mul timeout
    issue(1'b1, 5'd8, 32'd8, 32'd2, -1, 1'b0, -1, 1'b0);   // div timeout
    issue(1'b0, 5'd9, 32'd5, 32'd5, 5, 1'b0, 5, 1'b0);     // flush in BUSY, late ready
    issue(1'b0, 5'd10, 32'd3, 32'd4, 2, 1'b0, -1, 1'b0);
    issue(1'b1, 5'd11, 32'd50, 32'd7, 10, 1'b0, 4, 1'b1);  // reset mid-BUSY
    issue(1'b0, 5'd12, 32'd11, 32'd13, 1, 1'b0, -1, 1'b0); // minimum stall
    issue(1'b1, 5'd13, 32'd99, 32'd9, 1, 1'b0, -1, 1'b0);
    issue(1'b0, 5'd14, 32'hFFFF, 32'h10001, TO, 1'b0, -1, 1'b0); // ready on last BUSY cycle
    issue(1'b0, 5'd15, 32'd1, 32'd1, 5, 1'b0, 0, 1'b0);    // flushed at decode
    issue(1'b1, 5'd16, 32'd6, 32'd3, 5, 1'b0, 1, 1'b0);    // flushed in START
    noise(6);

    for (int i = 0; i < 30; i++) begin
      bit          dv;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      bit          exc;
      int          ab;
      bit          ab_rst;
      dv  = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      lat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, 20);
      exc = (dv && b == 0) || ($urandom_range(0, 7) == 0);
      ab  = -1;
      ab_rst = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 6) == 0)
        ab = $urandom_range(1, (lat < 0) ? 20 : lat + 1);
      issue(dv, rd, a, b, lat, exc, ab, ab_rst);
      noise($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Overall time limit
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d passed", n_total, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
